screen_config_controller: RTL and testbench

Sequencing controller for the VGA clock screen's configuration mode. It turns debounced push-button pulses into the configuration state, cursor position, cursor blink and edit strobes. Its outputs feed the character generator (`config_mode`, `cursor_location`, blink) and the RTC write-back logic (inc/dec strobes). It sits between the button conditioning stage and the screen top.

---
 rtl/screen_cfg_pkg.sv | 46 ++++
 rtl/frame_tick_gen.sv | 24 ++
 rtl/screen_config_controller.sv | 131 +++++++++++++
 tb/tb_screen_config_controller.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/screen_cfg_pkg.sv
// rtl/screen_cfg_pkg.sv - shared states, selector encodings and field indices for config mode
package screen_cfg_pkg;

   localparam logic [1:0] SEL_NONE  = 2'd0;
   localparam logic [1:0] SEL_HORA  = 2'd1;
   localparam logic [1:0] SEL_FECHA = 2'd2;
   localparam logic [1:0] SEL_TIMER = 2'd3;

   // State encodings equal the config_sel encodings so the selector is a plain flop copy.
   typedef enum logic [1:0] {
      ST_IDLE      = SEL_NONE,
      ST_CFG_HORA  = SEL_HORA,
      ST_CFG_FECHA = SEL_FECHA,
      ST_CFG_TIMER = SEL_TIMER
   } cfg_state_t;

   typedef enum logic [2:0] {
      ACT_NONE, ACT_HORA, ACT_FECHA, ACT_TIMER,
      ACT_RIGHT, ACT_LEFT, ACT_UP, ACT_DOWN
   } cfg_action_t;

   localparam int HORA_FIELDS  = 4;
   localparam int FECHA_FIELDS = 3;
   localparam int TIMER_FIELDS = 3;

   localparam logic [1:0] HORA_HH    = 2'd0;
   localparam logic [1:0] HORA_MM    = 2'd1;
   localparam logic [1:0] HORA_SS    = 2'd2;
   localparam logic [1:0] HORA_AM_PM = 2'd3;
   localparam logic [1:0] FECHA_DAY  = 2'd0;
   localparam logic [1:0] FECHA_MES  = 2'd1;
   localparam logic [1:0] FECHA_YEAR = 2'd2;
   localparam logic [1:0] TIMER_HH   = 2'd0;
   localparam logic [1:0] TIMER_MM   = 2'd1;
   localparam logic [1:0] TIMER_SS   = 2'd2;

   function automatic logic [1:0] last_field(input cfg_state_t s);
      case (s)
         ST_CFG_HORA:  return 2'(HORA_FIELDS - 1);
         ST_CFG_FECHA: return 2'(FECHA_FIELDS - 1);
         ST_CFG_TIMER: return 2'(TIMER_FIELDS - 1);
         default:      return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// rtl/frame_tick_gen.sv - one-cycle frame tick from the registered falling edge of vsync
module frame_tick_gen (
   input  logic clock,
   input  logic reset,
   input  logic vsync,
   output logic frame_tick
);

   logic vsync_q;
   logic vsync_hist;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vsync_q    <= 1'b1;
         vsync_hist <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         vsync_q    <= vsync;
         vsync_hist <= vsync_q;
         frame_tick <= vsync_hist & ~vsync_q;
      end
   end

endmodule

// File: rtl/screen_config_controller.sv
// rtl/screen_config_controller.sv - config-mode FSM: mode select, cursor, blink, timeout, edit strobes
module screen_config_controller
   import screen_cfg_pkg::*;
#(
   parameter int BLINK_FRAMES   = 30,
   parameter int TIMEOUT_FRAMES = 1800
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       btn_hora,
   input  logic       btn_fecha,
   input  logic       btn_timer,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       vsync,
   output logic       config_mode,
   output logic [1:0] config_sel,
   output logic [1:0] cursor_location,
   output logic       cursor_visible,
   output logic       edit_inc,
   output logic       edit_dec
);

   localparam int BW = $clog2(BLINK_FRAMES + 1);
   localparam int TW = $clog2(TIMEOUT_FRAMES + 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
   localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_FRAMES - 1);

   cfg_state_t    state;
   cfg_state_t    mode_target;
   cfg_action_t   act;
   logic          frame_tick;
   logic [1:0]    cmax;
   logic [BW-1:0] blink_cnt;
   logic [TW-1:0] to_cnt;

   frame_tick_gen u_frame_tick (
      .clock      (clock),
      .reset      (reset),
      .vsync      (vsync),
      .frame_tick (frame_tick)
   );

   // Arrow buttons only count as actions inside a config state.
   always_comb begin
      act = ACT_NONE;
      if (btn_hora)                  act = ACT_HORA;
      else if (btn_fecha)            act = ACT_FECHA;
      else if (btn_timer)            act = ACT_TIMER;
      else if (state != ST_IDLE) begin
         if (btn_right)              act = ACT_RIGHT;
         else if (btn_left)          act = ACT_LEFT;
         else if (btn_up)            act = ACT_UP;
         else if (btn_down)          act = ACT_DOWN;
      end
   end

   always_comb begin
      case (act)
         ACT_HORA:  mode_target = ST_CFG_HORA;
         ACT_FECHA: mode_target = ST_CFG_FECHA;
         ACT_TIMER: mode_target = ST_CFG_TIMER;
         default:   mode_target = ST_IDLE;
      endcase
      cmax = last_field(state);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state           <= ST_IDLE;
         config_mode     <= 1'b0;
         config_sel      <= SEL_NONE;
         cursor_location <= 2'd0;
         cursor_visible  <= 1'b1;
         edit_inc        <= 1'b0;
         edit_dec        <= 1'b0;
         blink_cnt       <= '0;
         to_cnt          <= '0;
      end else begin
         edit_inc <= 1'b0;
         edit_dec <= 1'b0;
         if (act != ACT_NONE) begin
            blink_cnt      <= '0;
            to_cnt         <= '0;
            cursor_visible <= 1'b1;
         end
         case (act)
            ACT_HORA, ACT_FECHA, ACT_TIMER: begin
               cursor_location <= 2'd0;
               if (state == mode_target) begin
                  state       <= ST_IDLE;
                  config_mode <= 1'b0;
                  config_sel  <= SEL_NONE;
               end else begin
                  state       <= mode_target;
                  config_mode <= 1'b1;
                  config_sel  <= mode_target;
               end
            end
            ACT_RIGHT: cursor_location <= (cursor_location == cmax) ? 2'd0 : cursor_location + 2'd1;
            ACT_LEFT:  cursor_location <= (cursor_location == 2'd0) ? cmax : cursor_location - 2'd1;
            ACT_UP:    edit_inc <= 1'b1;
            ACT_DOWN:  edit_dec <= 1'b1;
            default: begin
               if (state != ST_IDLE && frame_tick) begin
                  if (to_cnt == TO_LAST) begin
                     state           <= ST_IDLE;
                     config_mode     <= 1'b0;
                     config_sel      <= SEL_NONE;
                     cursor_location <= 2'd0;
                     cursor_visible  <= 1'b1;
                     blink_cnt       <= '0;
                     to_cnt          <= '0;
                  end else begin
                     to_cnt <= to_cnt + TW'(1);
                     if (blink_cnt == BLINK_LAST) begin
                        blink_cnt      <= '0;
                        cursor_visible <= ~cursor_visible;
                     end else begin
                        blink_cnt <= blink_cnt + BW'(1);
                     end
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_screen_config_controller.sv
// tb/tb_screen_config_controller.sv - directed and random checks of two controller instances
module tb_screen_config_controller;

   logic clock = 1'b0;
   logic reset;
   logic btn_hora, btn_fecha, btn_timer, btn_up, btn_down, btn_left, btn_right;
   logic vsync;
   logic a_mode, a_vis, a_inc, a_dec;
   logic [1:0] a_sel, a_cur;
   logic b_mode, b_vis, b_inc, b_dec;
   logic [1:0] b_sel, b_cur;

   screen_config_controller #(.BLINK_FRAMES(2), .TIMEOUT_FRAMES(5)) dut_a (
      .clock(clock), .reset(reset),
      .btn_hora(btn_hora), .btn_fecha(btn_fecha), .btn_timer(btn_timer),
      .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
      .vsync(vsync),
      .config_mode(a_mode), .config_sel(a_sel), .cursor_location(a_cur),
      .cursor_visible(a_vis), .edit_inc(a_inc), .edit_dec(a_dec)
   );

   screen_config_controller #(.BLINK_FRAMES(2), .TIMEOUT_FRAMES(9)) dut_b (
      .clock(clock), .reset(reset),
      .btn_hora(btn_hora), .btn_fecha(btn_fecha), .btn_timer(btn_timer),
      .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
      .vsync(vsync),
      .config_mode(b_mode), .config_sel(b_sel), .cursor_location(b_cur),
      .cursor_visible(b_vis), .edit_inc(b_inc), .edit_dec(b_dec)
   );

   always #5 clock = ~clock;

   localparam bit [6:0] B_HORA  = 7'h01;
   localparam bit [6:0] B_FECHA = 7'h02;
   localparam bit [6:0] B_TIMER = 7'h04;
   localparam bit [6:0] B_RIGHT = 7'h08;
   localparam bit [6:0] B_LEFT  = 7'h10;
   localparam bit [6:0] B_UP    = 7'h20;
   localparam bit [6:0] B_DOWN  = 7'h40;

   int checks = 0;
   int failures = 0;

   // Reference model: selection, cursor, and frames elapsed since the last accepted action.
   int m_sel[2], m_cur[2], m_f[2];
   bit m_inc[2], m_dec[2];
   int blink_p[2] = '{2, 2};
   int tmo_p[2]   = '{5, 9};
   bit vh[$];

   function automatic int nfields(int s);
      case (s)
         1: return 4;
         2, 3: return 3;
         default: return 1;
      endcase
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_sel[i] = 0; m_cur[i] = 0; m_f[i] = 0; m_inc[i] = 0; m_dec[i] = 0;
      end
      vh = {1'b1, 1'b1, 1'b1};
   endtask

   task automatic model_edge(bit [6:0] b, bit vs);
      bit tick;
      int act, n, tgt;
      tick = vh[0] && !vh[1];
      vh.push_back(vs);
      void'(vh.pop_front());
      for (int i = 0; i < 2; i++) begin
         act = -1;
         for (int k = 0; k < 7; k++)
            if (act < 0 && b[k] && (k < 3 || m_sel[i] != 0)) act = k;
         m_inc[i] = 0;
         m_dec[i] = 0;
         n = nfields(m_sel[i]);
         if (act >= 0) m_f[i] = 0;
         case (act)
            0, 1, 2: begin
               tgt = act + 1;
               m_sel[i] = (m_sel[i] == tgt) ? 0 : tgt;
               m_cur[i] = 0;
            end
            3: m_cur[i] = (m_cur[i] + 1) % n;
            4: m_cur[i] = (m_cur[i] + n - 1) % n;
            5: m_inc[i] = 1;
            6: m_dec[i] = 1;
            default: begin
               if (m_sel[i] != 0 && tick) begin
                  m_f[i]++;
                  if (m_f[i] == tmo_p[i]) begin
                     m_sel[i] = 0; m_cur[i] = 0; m_f[i] = 0;
                  end
               end
            end
         endcase
      end
   endtask

   function automatic int exp_vis(int i);
      if (m_sel[i] == 0) return 1;
      return ((m_f[i] / blink_p[i]) % 2 == 0) ? 1 : 0;
   endfunction

   task automatic cmp_dut(string p, int i, logic mode, logic [1:0] sel, logic [1:0] cur,
                          logic vis, logic inc, logic dec);
      chk({p, "_mode"}, mode, (m_sel[i] != 0) ? 1 : 0);
      chk({p, "_sel"}, sel, m_sel[i]);
      chk({p, "_cursor"}, cur, m_cur[i]);
      chk({p, "_visible"}, vis, exp_vis(i));
      chk({p, "_inc"}, inc, m_inc[i]);
      chk({p, "_dec"}, dec, m_dec[i]);
   endtask

   task automatic cycle(bit [6:0] b, bit vs);
      @(negedge clock);
      {btn_down, btn_up, btn_left, btn_right, btn_timer, btn_fecha, btn_hora} = b;
      vsync = vs;
      @(posedge clock);
      #1;
      model_edge(b, vs);
      cmp_dut("a", 0, a_mode, a_sel, a_cur, a_vis, a_inc, a_dec);
      cmp_dut("b", 1, b_mode, b_sel, b_cur, b_vis, b_inc, b_dec);
   endtask

   task automatic frame();
      cycle(7'h0, 1'b0);
      repeat (3) cycle(7'h0, 1'b1);
   endtask

   task automatic check_reset_values(string p);
      chk({p, "_mode"}, a_mode, 0);
      chk({p, "_sel"}, a_sel, 0);
      chk({p, "_cursor"}, a_cur, 0);
      chk({p, "_visible"}, a_vis, 1);
      chk({p, "_inc"}, a_inc, 0);
      chk({p, "_dec"}, a_dec, 0);
   endtask

   task automatic do_reset();
      @(negedge clock);
      {btn_down, btn_up, btn_left, btn_right, btn_timer, btn_fecha, btn_hora} = 7'h0;
      vsync = 1'b1;
      reset = 1'b1;
      #1;
      check_reset_values("rst");
      model_reset();
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      bit [6:0] b;
      bit vs;
      reset = 1'b1;
      vsync = 1'b1;
      {btn_down, btn_up, btn_left, btn_right, btn_timer, btn_fecha, btn_hora} = 7'h0;
      #1;
      check_reset_values("por");
      model_reset();
      @(negedge clock);
      reset = 1'b0;

      cycle(B_HORA, 1'b1);
      chk("enter_hora_sel", a_sel, 1);
      chk("enter_hora_mode", a_mode, 1);
      repeat (3) cycle(B_RIGHT, 1'b1);
      chk("hora_cursor3", a_cur, 3);
      cycle(B_RIGHT, 1'b1);
      chk("hora_wrap_right", a_cur, 0);
      cycle(B_FECHA, 1'b1);
      cycle(B_LEFT, 1'b1);
      chk("fecha_wrap_left", a_cur, 2);

      cycle(B_TIMER, 1'b1);
      cycle(B_FECHA | B_UP, 1'b1);
      chk("prio_sel", a_sel, 2);
      chk("prio_no_inc", a_inc, 0);
      cycle(B_DOWN, 1'b1);
      chk("dec_strobe", a_dec, 1);
      cycle(7'h0, 1'b1);
      chk("dec_one_cycle", a_dec, 0);

      // Blink on dut_b (long timeout); dut_a times out on the fifth frame.
      cycle(B_HORA, 1'b1);
      repeat (6) frame();
      chk("a_timed_out", a_mode, 0);
      frame();
      frame();
      cycle(B_UP, 1'b1);
      chk("blink_restart", b_vis, 1);
      repeat (4) frame();

      do_reset();
      cycle(B_FECHA, 1'b1);
      repeat (4) frame();
      chk("tmo_still_cfg", a_mode, 1);
      frame();
      chk("tmo_exit", a_mode, 0);
      cycle(B_FECHA, 1'b1);
      repeat (3) frame();
      cycle(7'h0, 1'b0);
      cycle(7'h0, 1'b1);
      cycle(B_RIGHT, 1'b1);
      cycle(7'h0, 1'b1);
      repeat (4) frame();
      chk("tmo_rearmed", a_mode, 1);
      frame();
      chk("tmo_exit2", a_mode, 0);

      // Asynchronous reset between edges while in CFG_HORA.
      cycle(B_HORA, 1'b1);
      #2;
      {btn_down, btn_up, btn_left, btn_right, btn_timer, btn_fecha, btn_hora} = 7'h0;
      vsync = 1'b1;
      reset = 1'b1;
      #1;
      check_reset_values("async");
      model_reset();
      reset = 1'b0;
      cycle(B_UP, 1'b1);
      chk("idle_up_no_inc", a_inc, 0);

      repeat (600) begin
         b = '0;
         for (int k = 0; k < 3; k++) b[k] = ($urandom_range(0, 29) == 0);
         for (int k = 3; k < 7; k++) b[k] = ($urandom_range(0, 5) == 0);
         vs = ($urandom_range(0, 3) != 0);
         cycle(b, vs);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
